input_rd_master: RTL and testbench

//  AXI4 read master feeding the input_cache burst port (rreq/radr/rack/rdata).

---
 rtl/input_rd_master.sv | 161 ++++++++++++++++
 tb/tb_input_rd_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_rd_master.sv
// input_rd_master: one 64-beat AXI4 INCR read burst per cache line fill, rack 1 cycle after each R handshake.
// Single outstanding AR; rready held through DATA/DRAIN. `RDMA_RRESP_CHK_EN adds sticky err/err_adr.
module input_rd_master #(
  parameter int AW    = 32,
  parameter int NBEAT = 64,
  parameter int BSZ   = 9
) (
  input  logic          clk,
  input  logic          xrst,
  input  logic          civ,
  input  logic [AW-1:0] base,
  input  logic          rreq,
  input  logic [23:0]   radr,
  output logic          rack,
  output logic [63:0]   rdata,
  output logic [AW-1:0] m_araddr,
  output logic [7:0]    m_arlen,
  output logic [2:0]    m_arsize,
  output logic [1:0]    m_arburst,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic [63:0]   m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rlast,
  input  logic          m_rvalid,
  output logic          m_rready
`ifdef RDMA_RRESP_CHK_EN
  ,
  output logic          err,
  output logic [AW-1:0] err_adr
`endif
);

  localparam int CW = $clog2(NBEAT);
  localparam logic [CW-1:0] LAST = CW'(NBEAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic            arvalid_q, arvalid_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic            rack_q, rack_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            abort_q, abort_d;
  logic            beat;
  logic            last;
  logic [AW-1:0]   line_base;

  assign line_base = {base[AW-1:BSZ], {BSZ{1'b0}}};
  assign m_rready  = (state_q == S_DATA) || (state_q == S_DRAIN);
  assign beat      = m_rvalid && m_rready;
  assign last      = (bcnt_q == LAST);

  assign m_araddr  = araddr_q;
  assign m_arvalid = arvalid_q;
  assign m_arlen   = 8'(NBEAT - 1);
  assign m_arsize  = 3'b011;
  assign m_arburst = 2'b01;
  assign rdata     = rdata_q;
  // An invalidate kills a rack already in flight while the burst is still live.
  assign rack      = rack_q && !(civ && (state_q == S_DATA));

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    bcnt_d    = bcnt_q;
    rack_d    = 1'b0;
    rdata_d   = rdata_q;
    abort_d   = abort_q;
    case (state_q)
      S_IDLE: begin
        // rack_q high here means the previous burst's last rack is on the wire this cycle.
        if (rreq && !civ && !rack_q) begin
          araddr_d  = line_base + AW'(radr);
          arvalid_d = 1'b1;
          abort_d   = 1'b0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (civ) abort_d = 1'b1;
        if (m_arready) begin
          arvalid_d = 1'b0;
          bcnt_d    = '0;
          state_d   = (abort_q || civ) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          rdata_d = m_rdata;
          rack_d  = !civ;
          bcnt_d  = bcnt_q + 1'b1;
        end
        if (beat && last) state_d = S_IDLE;
        else if (civ)     state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (beat) begin
          bcnt_d = bcnt_q + 1'b1;
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q   <= S_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      bcnt_q    <= '0;
      rack_q    <= 1'b0;
      rdata_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      bcnt_q    <= bcnt_d;
      rack_q    <= rack_d;
      rdata_q   <= rdata_d;
      abort_q   <= abort_d;
    end
  end

`ifdef RDMA_RRESP_CHK_EN
  logic          err_q, err_d;
  logic [AW-1:0] err_adr_q, err_adr_d;
  logic          err_hit;
  logic          unused_base;

  assign unused_base = ^base[BSZ-1:0];
  assign err_hit     = beat && ((m_rresp != 2'b00) || (m_rlast != last));

  always_comb begin
    err_d     = err_q | err_hit;
    err_adr_d = err_adr_q;
    if (err_hit && !err_q) err_adr_d = araddr_q;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      err_q     <= 1'b0;
      err_adr_q <= '0;
    end else begin
      err_q     <= err_d;
      err_adr_q <= err_adr_d;
    end
  end

  assign err     = err_q;
  assign err_adr = err_adr_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{m_rresp, m_rlast, base[BSZ-1:0]};
`endif

endmodule

// File: tb/tb_input_rd_master.sv
// Bench for input_rd_master: AXI slave + transaction-level model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_input_rd_master;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          xrst = 1'b1;
  logic          civ = 1'b0;
  logic [AW-1:0] base = '0;
  logic          rreq = 1'b0;
  logic [23:0]   radr = '0;
  logic          rack;
  logic [63:0]   rdata;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [63:0]   m_rdata = '0;
  logic [1:0]    m_rresp = '0;
  logic          m_rlast = 1'b0;
  logic          m_rvalid = 1'b0;
  logic          m_rready;
`ifdef RDMA_RRESP_CHK_EN
  logic          err;
  logic [AW-1:0] err_adr;
`endif

  input_rd_master #(.AW(AW), .NBEAT(64), .BSZ(9)) dut (
    .clk(clk), .xrst(xrst), .civ(civ), .base(base), .rreq(rreq), .radr(radr),
    .rack(rack), .rdata(rdata), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef RDMA_RRESP_CHK_EN
    , .err(err), .err_adr(err_adr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a, input int i);
    return {a, 32'(i) * 32'h0101_0101};
  endfunction

  // Transaction-level model: is a burst outstanding, has its AR gone, beats seen, aborted, rack due.
  bit          m_busy = 0, m_ard = 0, m_abort = 0, m_pend = 0;
  int          m_beats = 0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_dat = '0;

  always @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      m_busy = 0; m_ard = 0; m_abort = 0; m_pend = 0; m_beats = 0;
      m_addr = '0; m_dat = '0;
    end else begin : model_step
      bit hs, rk_now, pend_n;
      rk_now = m_pend && !(civ && m_busy && m_ard && !m_abort);
      hs     = m_busy && m_ard && m_rvalid;
      pend_n = hs && !m_abort && !civ;
      if (pend_n) m_dat = m_rdata;
      if (!m_busy) begin
        if (rreq && !civ && !rk_now) begin
          m_busy = 1; m_ard = 0; m_abort = 0; m_beats = 0;
          m_addr = {base[31:9], 9'd0} + {8'd0, radr};
        end
      end else if (!m_ard) begin
        if (civ) m_abort = 1;
        if (m_arready) m_ard = 1;
      end else begin
        if (civ) m_abort = 1;
        if (hs) begin
          m_beats++;
          if (m_beats == 64) m_busy = 0;
        end
      end
      m_pend = pend_n;
    end
  end

  int          ar_delay = 0;
  bit          gap_en = 0;
  int          err_beat = -1;
  int          ar_wait = 0;
  int          gcyc = 0;

  always @(posedge clk) begin
    #1;
    if (!xrst) begin
      m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0; ar_wait = 0; gcyc = 0;
    end else begin
      if (m_busy && !m_ard) begin
        m_arready = (ar_wait >= ar_delay);
        ar_wait++;
      end else begin
        m_arready = 0; ar_wait = 0;
      end
      if (m_busy && m_ard) begin
        m_rvalid = !(gap_en && (gcyc % 3 == 2));
        gcyc++;
        m_rdata = pat(m_addr, m_beats);
        m_rlast = (m_beats == 63);
        m_rresp = (m_beats == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_rvalid = 0; m_rlast = 0; m_rresp = 0; gcyc = 0;
      end
    end
  end

  int          rack_cnt = 0;
  int          arv_cnt = 0;
  logic [63:0] rk_log [0:4095];

  always @(negedge clk) begin : compare
    bit er;
    er = m_pend && !(civ && m_busy && m_ard && !m_abort);
    chk("arvalid", m_arvalid, m_busy && !m_ard);
    chk("araddr", m_araddr, m_addr);
    chk("rready", m_rready, m_busy && m_ard);
    chk("rack", rack, er);
    if (er) chk("rdata", rdata, m_dat);
    if (m_arvalid) arv_cnt++;
    if (rack) begin
      if (rack_cnt < 4096) rk_log[rack_cnt] = rdata;
      rack_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [23:0] a, input int civ_at, output int racks, output int s0);
    int t;
    bit cdone;
    s0 = rack_cnt; t = 0; cdone = 0;
    rreq = 1; radr = a;
    do begin
      tick(); t++;
      if (rack_cnt != s0) rreq = 0;
      civ = 0;
      if (civ_at >= 0 && !cdone && (rack_cnt - s0) == civ_at) begin
        civ = 1; cdone = 1;
      end
    end while ((rreq || m_busy) && t < 1000);
    civ = 0; rreq = 0;
    tick(); tick();
    chk("burst_done", (t < 1000), 1);
    racks = rack_cnt - s0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s0, a0, t;
    base = 32'h1000_0000;
    #1 xrst = 0;
    #11;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_rack", rack, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_rdata", rdata, 0);
    chk("arlen", m_arlen, 63);
    chk("arsize", m_arsize, 3'b011);
    chk("arburst", m_arburst, 2'b01);
    @(negedge clk); #1 xrst = 1;
    tick(); tick();

    // 1) plain burst
    a0 = arv_cnt;
    burst(24'h000A00, -1, r, s0);
    chk("t1_racks", r, 64);
    chk("t1_addr", m_araddr, 32'h1000_0A00);
    chk("t1_arv_cycles", arv_cnt - a0, 1);
    chk("t1_first", rk_log[s0], 64'h1000_0A00_0000_0000);
    chk("t1_last", rk_log[s0 + 63], 64'h1000_0A00_3F3F_3F3F);

    // 2) R gaps every third cycle
    gap_en = 1;
    burst(24'h001200, -1, r, s0);
    gap_en = 0;
    chk("t2_racks", r, 64);
    chk("t2_beat7", rk_log[s0 + 7], 64'h1000_1200_0707_0707);

    // 3) AR stalled 20 cycles
    ar_delay = 20;
    a0 = arv_cnt;
    burst(24'hFFFE00, -1, r, s0);
    ar_delay = 0;
    chk("t3_racks", r, 64);
    chk("t3_arv_cycles", arv_cnt - a0, 21);
    chk("t3_addr", m_araddr, 32'h10FF_FE00);

    // 4) invalidate after beat 10, then civ blocks an idle request, then normal service
    burst(24'h000200, 11, r, s0);
    chk("t4_abort_racks", r, 11);
    rreq = 1; civ = 1; radr = 24'h000800;
    tick();
    rreq = 0; civ = 0;
    tick(); tick();
    chk("t4_civ_blocks", m_arvalid, 0);
    burst(24'h000400, -1, r, s0);
    chk("t4_after_racks", r, 64);
    chk("t4_after_addr", m_araddr, 32'h1000_0400);

    // address wrap, low base bits ignored
    base = 32'hFFFF_FFFF;
    burst(24'h000400, -1, r, s0);
    chk("wrap_addr", m_araddr, 32'h0000_0200);
    chk("wrap_racks", r, 64);
    base = 32'h1000_0000;

    // 5) async reset mid-DATA
    s0 = rack_cnt; rreq = 1; radr = 24'h000600; t = 0;
    while ((rack_cnt - s0) < 5 && t < 300) begin
      tick(); t++;
      if (rack_cnt != s0) rreq = 0;
    end
    rreq = 0;
    chk("t5_reached_data", (t < 300), 1);
    @(posedge clk); #3;
    xrst = 0;
    #1;
    chk("t5_arvalid", m_arvalid, 0);
    chk("t5_rready", m_rready, 0);
    chk("t5_rack", rack, 0);
    chk("t5_araddr", m_araddr, 0);
    chk("t5_rdata", rdata, 0);
    @(negedge clk); @(negedge clk); #1 xrst = 1;
    tick();
    burst(24'h000600, -1, r, s0);
    chk("t5_after_racks", r, 64);

`ifdef RDMA_RRESP_CHK_EN
    // 6) SLVERR on beat 5
    chk("t6_err_clear", err, 0);
    err_beat = 5;
    burst(24'h000800, -1, r, s0);
    err_beat = -1;
    chk("t6_racks", r, 64);
    chk("t6_err", err, 1);
    chk("t6_err_adr", err_adr, 32'h1000_0800);
    chk("t6_beat5", rk_log[s0 + 5], 64'h1000_0800_0505_0505);
    burst(24'h000C00, -1, r, s0);
    chk("t6_err_sticky", err, 1);
    chk("t6_err_adr_held", err_adr, 32'h1000_0800);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
